// File: rtl/srom_arb_pkg.sv
// Shared constants, FSM encodings and read-lane steering
// for the two-port AHB-lite SROM arbiter.
package srom_arb_pkg;

  localparam logic [1:0] HT_IDLE = 2'b00;
  localparam logic [1:0] HT_BUSY = 2'b01;
  localparam logic [1:0] HT_NSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ  = 2'b11;

  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_HALF = 3'd1;
  localparam logic [2:0] SZ_WORD = 3'd2;

  typedef enum logic [2:0] {
    P_IDLE,
    P_PEND,
    P_ACC,
    P_DONE,
    P_ERR1,
    P_ERR2
  } port_st_e;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } seq_st_e;

  function automatic logic [31:0] lane_steer(
    input logic [31:0] d,
    input logic [1:0]  a,
    input logic [2:0]  sz
  );
    logic [31:0] r;
    r = d;
    if (sz == SZ_BYTE) begin
      case (a)
        2'd0:    r = {4{d[7:0]}};
        2'd1:    r = {4{d[15:8]}};
        2'd2:    r = {4{d[23:16]}};
        default: r = {4{d[31:24]}};
      endcase
    end else if (sz == SZ_HALF) begin
      r = a[1] ? {2{d[31:16]}} : {2{d[15:0]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/srom_arb_port.sv
// Per-port AHB-lite front-end: accept, pending capture,
// wait-state / error sequencing and read-data return.
module srom_arb_port
  import srom_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shready_i,
  input  logic        shsel_i,
  input  logic [31:0] shaddr_i,
  input  logic [1:0]  shtrans_i,
  input  logic        shwrite_i,
  input  logic [2:0]  shsize_i,
  input  logic [31:0] romdout_i,
  input  logic        gnt_i,
  input  logic        done_i,
  output logic        req_o,
  output logic [31:0] req_addr_o,
  output logic [31:0] shrdata_o,
  output logic        shready_o,
  output logic        shresp_o
);

  port_st_e    state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic        open, acc, acc_rd, acc_wr;

  // New address phases are only taken while this slave shows HREADY high.
  assign open = (state_q == P_IDLE) | (state_q == P_DONE)
              | (state_q == P_ERR2);
  assign acc    = open & shready_i & shsel_i & shtrans_i[1];
  assign acc_rd = acc & ~shwrite_i;
  assign acc_wr = acc & shwrite_i;

  assign req_o      = (state_q == P_PEND) | acc_rd;
  assign req_addr_o = (state_q == P_PEND) ? addr_q : shaddr_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      P_IDLE, P_DONE, P_ERR2: begin
        if (acc_wr)      state_d = P_ERR1;
        else if (acc_rd) state_d = gnt_i ? P_ACC : P_PEND;
        else             state_d = P_IDLE;
      end
      P_PEND: if (gnt_i) state_d = P_ACC;
      P_ACC:  if (done_i) state_d = P_DONE;
      P_ERR1: state_d = P_ERR2;
      default: state_d = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= P_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        addr_q <= shaddr_i;
        size_q <= shsize_i;
      end
    end
  end

  assign shready_o = ~((state_q == P_PEND) | (state_q == P_ACC)
                     | (state_q == P_ERR1));
  assign shresp_o  = (state_q == P_ERR1) | (state_q == P_ERR2);
  assign shrdata_o = (state_q == P_DONE)
                   ? lane_steer(romdout_i, addr_q[1:0], size_q)
                   : 32'h0;

endmodule

// File: rtl/ahb_srom_arb2.sv
// Two-port AHB-lite SROM front-end: round-robin arbiter
// and fixed-latency SROM access sequencer.
module ahb_srom_arb2
  import srom_arb_pkg::*;
#(
  parameter int WAIT_CYC = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_shready_in,
  input  logic        p0_shsel,
  input  logic [31:0] p0_shaddr,
  input  logic [1:0]  p0_shtrans,
  input  logic        p0_shwrite,
  input  logic [2:0]  p0_shsize,
  output logic [31:0] p0_shrdata,
  output logic        p0_shready_out,
  output logic        p0_shresp,
  input  logic        p1_shready_in,
  input  logic        p1_shsel,
  input  logic [31:0] p1_shaddr,
  input  logic [1:0]  p1_shtrans,
  input  logic        p1_shwrite,
  input  logic [2:0]  p1_shsize,
  output logic [31:0] p1_shrdata,
  output logic        p1_shready_out,
  output logic        p1_shresp,
  output logic        romcs_n,
  output logic [31:0] romaddr,
  input  logic [31:0] romdout
);

  localparam logic [2:0] WC = WAIT_CYC[2:0];

  logic        r0, r1, g0, g1, d0, d1;
  logic [31:0] a0, a1;

  seq_st_e     seq_q, seq_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        own_q, own_d;
  logic        last_q, last_d;
  logic        cs_q, cs_d;
  logic [31:0] addr_q, addr_d;
  logic        fin, slot, pick0;

  assign fin   = (seq_q == S_BUSY) & (cnt_q == WC);
  assign slot  = (seq_q == S_IDLE) | fin;
  assign pick0 = r0 & (~r1 | last_q);
  assign g0    = slot & pick0;
  assign g1    = slot & r1 & ~pick0;
  assign d0    = fin & ~own_q;
  assign d1    = fin & own_q;

  always_comb begin
    seq_d  = seq_q;
    cnt_d  = cnt_q;
    own_d  = own_q;
    last_d = last_q;
    cs_d   = cs_q;
    addr_d = addr_q;
    if (slot & (r0 | r1)) begin
      seq_d  = S_BUSY;
      cnt_d  = '0;
      own_d  = ~pick0;
      cs_d   = 1'b0;
      addr_d = pick0 ? a0 : a1;
      // the pointer only moves when a tie was actually arbitrated
      if (r0 & r1) last_d = ~pick0;
    end else if (fin) begin
      seq_d = S_IDLE;
      cs_d  = 1'b1;
    end else if (seq_q == S_BUSY) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q  <= S_IDLE;
      cnt_q  <= '0;
      own_q  <= 1'b0;
      last_q <= 1'b1;
      cs_q   <= 1'b1;
      addr_q <= '0;
    end else begin
      seq_q  <= seq_d;
      cnt_q  <= cnt_d;
      own_q  <= own_d;
      last_q <= last_d;
      cs_q   <= cs_d;
      addr_q <= addr_d;
    end
  end

  assign romcs_n = cs_q;
  assign romaddr = addr_q;

  srom_arb_port u_p0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .shready_i  (p0_shready_in),
    .shsel_i    (p0_shsel),
    .shaddr_i   (p0_shaddr),
    .shtrans_i  (p0_shtrans),
    .shwrite_i  (p0_shwrite),
    .shsize_i   (p0_shsize),
    .romdout_i  (romdout),
    .gnt_i      (g0),
    .done_i     (d0),
    .req_o      (r0),
    .req_addr_o (a0),
    .shrdata_o  (p0_shrdata),
    .shready_o  (p0_shready_out),
    .shresp_o   (p0_shresp)
  );

  srom_arb_port u_p1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .shready_i  (p1_shready_in),
    .shsel_i    (p1_shsel),
    .shaddr_i   (p1_shaddr),
    .shtrans_i  (p1_shtrans),
    .shwrite_i  (p1_shwrite),
    .shsize_i   (p1_shsize),
    .romdout_i  (romdout),
    .gnt_i      (g1),
    .done_i     (d1),
    .req_o      (r1),
    .req_addr_o (a1),
    .shrdata_o  (p1_shrdata),
    .shready_o  (p1_shready_out),
    .shresp_o   (p1_shresp)
  );

endmodule

// File: tb/tb_ahb_srom_arb2.sv
// Directed bench: four DUTs (WAIT_CYC 0..3) share stimulus,
// each test checks the instance selected by s.
module tb_ahb_srom_arb2;

  logic        clk;
  logic        rst_n;
  logic        hrdy;
  logic        sel   [2];
  logic [1:0]  trans [2];
  logic [31:0] addr  [2];
  logic        wr    [2];
  logic [2:0]  size  [2];

  logic [31:0] rdata [4][2];
  logic        rdy   [4][2];
  logic        resp  [4][2];
  logic        cs    [4];
  logic [31:0] raddr [4];

  int s;
  int n_tests;
  int n_fail;

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    logic [31:0] r;
    case (a[31:2])
      30'h40:  r = 32'h11223344;
      30'h80:  r = 32'hAABBCCDD;
      default: r = {a[15:0], a[15:0] ^ 16'hFFFF};
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [31:0] dout;
    initial dout = '0;
    always @(posedge clk) if (!cs[g]) dout <= rom_f(raddr[g]);

    ahb_srom_arb2 #(.WAIT_CYC(g)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .p0_shready_in  (hrdy),
      .p0_shsel       (sel[0]),
      .p0_shaddr      (addr[0]),
      .p0_shtrans     (trans[0]),
      .p0_shwrite     (wr[0]),
      .p0_shsize      (size[0]),
      .p0_shrdata     (rdata[g][0]),
      .p0_shready_out (rdy[g][0]),
      .p0_shresp      (resp[g][0]),
      .p1_shready_in  (hrdy),
      .p1_shsel       (sel[1]),
      .p1_shaddr      (addr[1]),
      .p1_shtrans     (trans[1]),
      .p1_shwrite     (wr[1]),
      .p1_shsize      (size[1]),
      .p1_shrdata     (rdata[g][1]),
      .p1_shready_out (rdy[g][1]),
      .p1_shresp      (resp[g][1]),
      .romcs_n        (cs[g]),
      .romaddr        (raddr[g]),
      .romdout        (dout)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv(input int p, input logic [31:0] a,
                     input logic w, input logic [2:0] sz);
    sel[p]   = 1'b1;
    trans[p] = 2'b10;
    addr[p]  = a;
    wr[p]    = w;
    size[p]  = sz;
  endtask

  task automatic rd1(input int p, input logic [31:0] a,
                     input logic [2:0] sz, input logic [31:0] exp,
                     input int lat, input string tag);
    int n;
    drv(p, a, 1'b0, sz);
    tick();
    trans[p] = 2'b00;
    n = 1;
    while (!rdy[s][p] && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_data"}, rdata[s][p], exp);
    tick();
    chk({tag, "_zero"}, rdata[s][p], 32'h0);
  endtask

  task automatic tie(input logic [31:0] a0, input logic [31:0] a1,
                     input int c0, input int c1,
                     input logic [31:0] e0, input logic [31:0] e1,
                     input logic [31:0] fa, input string tag);
    int low, dc0, dc1;
    logic [31:0] dd0, dd1;
    low = 0; dc0 = 0; dc1 = 0; dd0 = '0; dd1 = '0;
    drv(0, a0, 1'b0, 3'd2);
    drv(1, a1, 1'b0, 3'd2);
    tick();
    trans[0] = 2'b00;
    trans[1] = 2'b00;
    for (int c = 1; c <= 10; c++) begin
      if (!cs[s]) low++;
      if (c == 1) chk({tag, "_first"}, raddr[s], fa);
      if (rdy[s][0] && dc0 == 0) begin dc0 = c; dd0 = rdata[s][0]; end
      if (rdy[s][1] && dc1 == 0) begin dc1 = c; dd1 = rdata[s][1]; end
      tick();
    end
    chk({tag, "_cslow"}, 32'(low), 32'd6);
    chk({tag, "_p0lat"}, 32'(dc0), 32'(c0));
    chk({tag, "_p1lat"}, 32'(dc1), 32'(c1));
    chk({tag, "_p0dat"}, dd0, e0);
    chk({tag, "_p1dat"}, dd1, e1);
  endtask

  initial begin
    int low, bad, idx, got, lastd, iss;
    logic pcs;
    logic [31:0] ba [4];
    logic [31:0] be [4];
    logic [31:0] ia [4];

    n_tests = 0; n_fail = 0; s = 0;
    hrdy = 1'b1;
    for (int p = 0; p < 2; p++) begin
      sel[p] = 1'b0; trans[p] = 2'b00; addr[p] = '0;
      wr[p] = 1'b0; size[p] = 3'd2;
    end
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    tick();

    chk("rst_cs", 32'(cs[0]), 32'd1);
    chk("rst_addr", raddr[0], 32'h0);
    chk("rst_rdy0", 32'(rdy[0][0]), 32'd1);
    chk("rst_rdy1", 32'(rdy[0][1]), 32'd1);
    chk("rst_resp0", 32'(resp[0][0]), 32'd0);
    chk("rst_rdata0", rdata[0][0], 32'h0);

    // W=0 word read, cycle by cycle
    drv(0, 32'h100, 1'b0, 3'd2);
    tick();
    trans[0] = 2'b00;
    chk("w0_cs", 32'(cs[0]), 32'd0);
    chk("w0_addr", raddr[0], 32'h100);
    chk("w0_wait", 32'(rdy[0][0]), 32'd0);
    tick();
    chk("w0_done", 32'(rdy[0][0]), 32'd1);
    chk("w0_data", rdata[0][0], 32'h11223344);
    chk("w0_csoff", 32'(cs[0]), 32'd1);
    tick();
    chk("w0_zero", rdata[0][0], 32'h0);
    idle(4);

    rd1(1, 32'h203, 3'd0, 32'hAAAAAAAA, 2, "p1_byte");
    rd1(1, 32'h202, 3'd1, 32'hAABBAABB, 2, "p1_half");
    rd1(0, 32'h201, 3'd0, 32'hCCCCCCCC, 2, "p0_byte1");
    idle(10);

    s = 2;
    tie(32'h100, 32'h200, 4, 7, 32'h11223344, 32'hAABBCCDD,
        32'h100, "tie1");
    idle(6);
    tie(32'h300, 32'h304, 7, 4, 32'h0300FCFF, 32'h0304FCFB,
        32'h304, "tie2");
    idle(6);

    // p1 write error alongside a p0 read
    drv(0, 32'h100, 1'b0, 3'd2);
    drv(1, 32'h40, 1'b1, 3'd2);
    tick();
    trans[0] = 2'b00;
    trans[1] = 2'b00;
    low = 0;
    for (int c = 1; c <= 6; c++) begin
      if (!cs[s]) low++;
      if (c == 1) begin
        chk("err_addr", raddr[s], 32'h100);
        chk("err1_rdy", 32'(rdy[s][1]), 32'd0);
        chk("err1_resp", 32'(resp[s][1]), 32'd1);
      end
      if (c == 2) begin
        chk("err2_rdy", 32'(rdy[s][1]), 32'd1);
        chk("err2_resp", 32'(resp[s][1]), 32'd1);
      end
      if (c == 3) chk("err_end", 32'(resp[s][1]), 32'd0);
      if (c == 4) begin
        chk("err_p0rdy", 32'(rdy[s][0]), 32'd1);
        chk("err_p0dat", rdata[s][0], 32'h11223344);
      end
      tick();
    end
    chk("err_cslow", 32'(low), 32'd3);
    idle(6);

    // W=1 back-to-back reads from p0
    s = 1;
    ba[0] = 32'h300; ba[1] = 32'h304; ba[2] = 32'h308; ba[3] = 32'h30C;
    be[0] = 32'h0300FCFF; be[1] = 32'h0304FCFB;
    be[2] = 32'h0308FCF7; be[3] = 32'h030CFCF3;
    for (int i = 0; i < 4; i++) ia[i] = '0;
    idx = 0; got = 0; lastd = 0; iss = 0; pcs = 1'b1;
    drv(0, ba[0], 1'b0, 3'd2);
    for (int c = 0; c < 24; c++) begin
      if (!cs[s] && pcs) begin
        if (iss < 4) ia[iss] = raddr[s];
        iss++;
      end
      pcs = cs[s];
      if (c > 0 && rdy[s][0] && got < 4 && idx > got) begin
        chk($sformatf("b2b_data%0d", got), rdata[s][0], be[got]);
        if (got > 0)
          chk($sformatf("b2b_gap%0d", got), 32'(c - lastd), 32'd3);
        lastd = c;
        got++;
      end
      if (rdy[s][0] && trans[0] == 2'b10) begin
        tick();
        idx++;
        if (idx < 4) addr[0] = ba[idx];
        else trans[0] = 2'b00;
      end else begin
        tick();
      end
    end
    chk("b2b_count", 32'(got), 32'd4);
    chk("b2b_issues", 32'(iss), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("b2b_addr%0d", i), ia[i], ba[i]);
    idle(4);

    // W=3 reset during second romcs_n-low cycle
    s = 3;
    drv(0, 32'h100, 1'b0, 3'd2);
    tick();
    trans[0] = 2'b00;
    tick();
    chk("rst2_cs_pre", 32'(cs[s]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst2_cs", 32'(cs[s]), 32'd1);
    chk("rst2_rdy", 32'(rdy[s][0]), 32'd1);
    chk("rst2_addr", raddr[s], 32'h0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (!cs[s] || !rdy[s][0] || rdata[s][0] != 32'h0) bad++;
      tick();
    end
    chk("rst2_quiet", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
